// File: rtl/ppu_out_wb.sv
// ppu_out_wb: writeback stage behind the PPU array.
// Issues credits so that every vector launched into the non-stallable PPU
// pipeline owns a FIFO slot, captures tagged PPU outputs into a small FIFO and
// writes them to the output feature-map buffer with row/column address
// generation.
`ifndef S
`define S 2
`endif
`ifndef R
`define R 2
`endif

module ppu_out_wb #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  n_cols,
  input  logic [CNT_WIDTH-1:0]  n_rows,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  issue,
  output logic                  issue_ok,
  input  logic                  in_valid,
  input  logic [`S*`R*8-1:0]    in_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [`S*`R*8-1:0]    wr_data,
  input  logic                  wr_rdy
);

  localparam int DW = `S*`R*8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int TW = 2 * CNT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  ncols_q, ncols_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [TW-1:0]         total_q, total_d;
  logic [TW-1:0]         issued_q, issued_d;
  logic [TW-1:0]         xfer_cnt_q, xfer_cnt_d;
  logic [OW-1:0]         out_q, out_d;
  logic [OW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  issue_ok_q, issue_ok_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic [DW-1:0]         mem_q [FIFO_DEPTH];

  logic                  start_acc_s;
  logic                  issue_acc_s;
  logic                  xfer_s;
  logic                  push_s;
  logic                  err_set_s;
  logic [OW-1:0]         in_flight_s;

  // Next-state logic: credits, FIFO pointers, address generation and job FSM.
  always_comb begin
    start_acc_s = start && (state_q == ST_IDLE);
    issue_acc_s = issue && issue_ok_q;
    xfer_s      = wr_en_q && wr_rdy;
    // Vectors launched but not yet arrived from the PPU array.
    in_flight_s = out_q - cnt_q;
    push_s      = in_valid && (in_flight_s != {OW{1'b0}});
    err_set_s   = (issue && !issue_ok_q) || (in_valid && (in_flight_s == {OW{1'b0}}));

    state_d  = state_q;
    ncols_d  = ncols_q;
    stride_d = stride_q;
    total_d  = total_q;

    case ({issue_acc_s, xfer_s})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase

    case ({push_s, xfer_s})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase

    issued_d   = issue_acc_s ? (issued_q + TW'(1)) : issued_q;
    xfer_cnt_d = xfer_s ? (xfer_cnt_q + TW'(1)) : xfer_cnt_q;
    wptr_d     = push_s ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d     = xfer_s ? (rptr_q + PW'(1)) : rptr_q;

    if (xfer_s) begin
      if (col_q == (ncols_q - CNT_WIDTH'(1))) begin
        col_d      = {CNT_WIDTH{1'b0}};
        row_base_d = row_base_q + stride_q;
      end else begin
        col_d      = col_q + CNT_WIDTH'(1);
        row_base_d = row_base_q;
      end
    end else begin
      col_d      = col_q;
      row_base_d = row_base_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_acc_s) begin
          ncols_d    = n_cols;
          stride_d   = row_stride;
          total_d    = TW'(n_cols) * TW'(n_rows);
          issued_d   = {TW{1'b0}};
          xfer_cnt_d = {TW{1'b0}};
          out_d      = {OW{1'b0}};
          cnt_d      = {OW{1'b0}};
          wptr_d     = {PW{1'b0}};
          rptr_d     = {PW{1'b0}};
          row_base_d = base_addr;
          col_d      = {CNT_WIDTH{1'b0}};
          state_d    = ((n_cols == {CNT_WIDTH{1'b0}}) || (n_rows == {CNT_WIDTH{1'b0}}))
                       ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer_s && (xfer_cnt_q == (total_q - TW'(1)))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Errors raised in the same cycle as an accepted start still stick.
    err_d = err_set_s || (err_q && !start_acc_s);

    // Outputs are registered from the next-state view so they describe the
    // counters as they stand in the cycle they are presented.
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    issue_ok_d = (state_d == ST_RUN) && (out_d < OW'(FIFO_DEPTH)) && (issued_d < total_d);
    wr_en_d    = (state_d == ST_RUN) && (cnt_d != {OW{1'b0}});
    wr_addr_d  = row_base_d + ADDR_WIDTH'(col_d);
    // A vector pushed into an (effectively) empty FIFO becomes the head directly.
    wr_data_d  = (push_s && (rptr_d == wptr_q)) ? in_data : mem_q[rptr_d];
  end

  // FIFO storage; pointers and occupancy carry the reset, the data does not.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ncols_q    <= {CNT_WIDTH{1'b0}};
      stride_q   <= {ADDR_WIDTH{1'b0}};
      total_q    <= {TW{1'b0}};
      issued_q   <= {TW{1'b0}};
      xfer_cnt_q <= {TW{1'b0}};
      out_q      <= {OW{1'b0}};
      cnt_q      <= {OW{1'b0}};
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      row_base_q <= {ADDR_WIDTH{1'b0}};
      col_q      <= {CNT_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      issue_ok_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_WIDTH{1'b0}};
      wr_data_q  <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      ncols_q    <= ncols_d;
      stride_q   <= stride_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      xfer_cnt_q <= xfer_cnt_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      issue_ok_q <= issue_ok_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign issue_ok = issue_ok_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_ppu_out_wb.sv
// Testbench for ppu_out_wb: a delayed PPU model and a transaction-level
// reference (job address list, issue/capture/transfer counts, sticky error)
// checked every cycle against the DUT outputs.
`ifndef S
`define S 2
`endif
`ifndef R
`define R 2
`endif

module tb_ppu_out_wb;
  localparam int DW    = `S*`R*8;
  localparam int DEPTH = 8;
  localparam int DELAY = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   base_addr = 16'd0;
  logic [15:0]   n_cols = 16'd0;
  logic [15:0]   n_rows = 16'd0;
  logic [15:0]   row_stride = 16'd0;
  logic          busy, done, err, issue_ok, wr_en;
  logic          issue = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [15:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_rdy = 1'b0;

  always #5 clk = ~clk;

  ppu_out_wb #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .n_cols(n_cols), .n_rows(n_rows), .row_stride(row_stride),
    .busy(busy), .done(done), .err(err), .issue(issue), .issue_ok(issue_ok),
    .in_valid(in_valid), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // PPU pipeline model and reference state
  int            cyc = 0;
  logic [DW-1:0] pipe_data[$];
  int            pipe_due[$];
  logic [15:0]   exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            accepted = 0, captured = 0, xfers = 0, total = 0;
  int            first_xfer = -1, last_xfer = -1, first_valid = -1;
  bit            job_active = 0, model_on = 0, err_model = 0;
  bit            auto_issue = 0, spurious = 0, force_valid = 0, post_rst_valid = 0;
  int            rdy_mode = 1, issue_pct = 100;

  task automatic start_model();
    total = int'(n_cols) * int'(n_rows);
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; k < total; k++) begin
      exp_addr.push_back(16'(int'(base_addr) + (k / int'(n_cols)) * int'(row_stride) + (k % int'(n_cols))));
    end
    accepted = 0; captured = 0; xfers = 0;
    first_xfer = -1; last_xfer = -1; first_valid = -1;
    job_active = 1;
  endtask

  task automatic cycle();
    int            inflight;
    bit            errset, ending, start_acc;
    logic [DW-1:0] d;
    if (pipe_due.size() > 0 && pipe_due[0] <= cyc) begin
      in_valid = 1'b1;
      in_data  = pipe_data.pop_front();
      void'(pipe_due.pop_front());
      if (rstn) post_rst_valid = 1;
    end else if (force_valid) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom());
    end else begin
      in_valid = 1'b0;
      in_data  = DW'($urandom());
    end
    case (rdy_mode)
      0:       wr_rdy = 1'b0;
      1:       wr_rdy = 1'b1;
      default: wr_rdy = ($urandom_range(0, 3) != 0);
    endcase
    issue = spurious || (auto_issue && issue_ok && ($urandom_range(0, 99) < issue_pct));

    if (model_on) begin
      check_eq("busy", busy, job_active);
      check_eq("done", done, job_active && (xfers == total));
      check_eq("issue_ok", issue_ok,
               job_active && (xfers < total) && ((accepted - xfers) < DEPTH) && (accepted < total));
      check_eq("wr_en", wr_en, job_active && (xfers < total) && ((captured - xfers) > 0));
      check_eq("err", err, err_model);

      inflight  = accepted - captured;
      errset    = (issue && !issue_ok) || (in_valid && inflight == 0);
      ending    = job_active && (xfers == total);
      start_acc = start && !job_active;
      if (wr_en && wr_rdy) begin
        if (exp_addr.size() == 0 || exp_data.size() == 0) begin
          check_eq("xfer_extra", wr_en, 1'b0);
        end else begin
          check_eq("wr_addr", wr_addr, exp_addr.pop_front());
          check_eq("wr_data", wr_data, exp_data.pop_front());
        end
        xfers++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      if (in_valid && inflight > 0) begin
        captured++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (issue && issue_ok) accepted++;
      if (ending) job_active = 0;
      if (start_acc) start_model();
      err_model = (err_model && !start_acc) || errset;
    end
    if (issue && issue_ok) begin
      d = DW'($urandom());
      pipe_data.push_back(d);
      pipe_due.push_back(cyc + DELAY);
      exp_data.push_back(d);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic start_job(input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] r, input logic [15:0] s);
    base_addr = b; n_cols = c; n_rows = r; row_stride = s;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_job(input int budget);
    for (int i = 0; i < budget && job_active; i++) cycle();
    check_eq("job_timeout", job_active, 1'b0);
    check_eq("all_written", exp_addr.size(), 0);
    check_eq("issued_total", accepted, total);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_issue_ok", issue_ok, 1'b0);
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 16'h0000);
    rstn = 1'b1;
    model_on = 1;
    idle(2);

    // Basic 3x2 job, back-to-back issue, buffer always ready
    rdy_mode = 1; auto_issue = 1; issue_pct = 100;
    start_job(16'h0100, 16'd3, 16'd2, 16'h0010);
    wait_job(200);
    check_eq("t1_first_latency", first_xfer, first_valid + 1);
    check_eq("t1_back_to_back", last_xfer - first_xfer, 5);
    idle(2);

    // Zero-size job
    start_job(16'h0200, 16'd5, 16'd0, 16'h0010);
    wait_job(10);
    idle(2);

    // Spurious in_valid while idle, cleared by start, then spurious issue
    force_valid = 1; cycle(); force_valid = 0;
    idle(1);
    check_eq("t4_err_valid", err, 1'b1);
    start_job(16'h0300, 16'd1, 16'd1, 16'h0001);
    check_eq("t4_err_cleared", err, 1'b0);
    wait_job(100);
    spurious = 1; cycle(); spurious = 0;
    idle(1);
    check_eq("t4_err_issue", err, 1'b1);

    // Credit limit with the buffer stalled
    rdy_mode = 0;
    start_job(16'h0040, 16'd4, 16'd4, 16'h0020);
    idle(30);
    check_eq("t2_credits", accepted, DEPTH);
    check_eq("t2_issue_ok_low", issue_ok, 1'b0);
    spurious = 1; cycle(); spurious = 0;
    idle(1);
    check_eq("t2_err_issue", err, 1'b1);
    rdy_mode = 1;
    wait_job(300);
    idle(2);

    // Address wrap
    start_job(16'hFFFE, 16'd4, 16'd1, 16'h0100);
    wait_job(200);
    idle(2);

    // Randomized jobs
    rdy_mode = 2; issue_pct = 60;
    for (int j = 0; j < 5; j++) begin
      start_job(16'($urandom()), 16'($urandom_range(1, 5)), 16'($urandom_range(1, 4)),
                16'($urandom()));
      wait_job(1000);
      idle($urandom_range(1, 3));
    end

    // Reset in the middle of a job
    rdy_mode = 1; issue_pct = 100;
    start_job(16'h0500, 16'd3, 16'd2, 16'h0010);
    for (int i = 0; i < 200 && xfers < 3; i++) cycle();
    check_eq("t6_three_written", xfers, 3);
    post_rst_valid = 0;
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_done", done, 1'b0);
    check_eq("t6_err", err, 1'b0);
    check_eq("t6_issue_ok", issue_ok, 1'b0);
    check_eq("t6_wr_en", wr_en, 1'b0);
    check_eq("t6_wr_addr", wr_addr, 16'h0000);
    check_eq("t6_wr_data", wr_data, '0);
    model_on = 0;
    job_active = 0; err_model = 0;
    accepted = 0; captured = 0; xfers = 0; total = 0;
    exp_addr.delete(); exp_data.delete();
    auto_issue = 0;
    idle(2);
    rstn = 1'b1;
    model_on = 1;
    for (int i = 0; i < 50 && pipe_due.size() > 0; i++) cycle();
    idle(2);
    check_eq("t6_err_dropped", err, post_rst_valid);
    auto_issue = 1;
    start_job(16'h0600, 16'd3, 16'd2, 16'h0010);
    wait_job(200);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
